// File: rtl/dot_product_pkg.sv
// Shared sizing constants and FSM state encoding for the dot-product sequencer.
package dot_product_pkg;
  localparam int Data_Width = 8;
  localparam int Addr_Width = 4;
  localparam int Ram_Depth  = 1 << Addr_Width;
  localparam int Para_Deg   = 4;
  localparam int Word_Width = Para_Deg * Data_Width;
  localparam int Prod_Width = 2 * Data_Width;
  localparam int Acc_Width  = Para_Deg * Data_Width;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/dot_product_ctrl_if.sv
// SRAM-side bus: shared read port for both operand SRAMs and the result SRAM write port.
interface dot_product_ctrl_if;
  import dot_product_pkg::*;

  logic                  In_Chip_Select;
  logic                  In_En_Read;
  logic [Addr_Width-1:0] In_Read_Addr;
  logic [Word_Width-1:0] In0_Read_Data;
  logic [Word_Width-1:0] In1_Read_Data;
  logic                  Out_Chip_Select;
  logic                  Out_En_Write;
  logic [Addr_Width-1:0] Out_Write_Addr;
  logic [Word_Width-1:0] Out_Write_Data;

  modport master (
    output In_Chip_Select, In_En_Read, In_Read_Addr,
    input  In0_Read_Data, In1_Read_Data,
    output Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data
  );

  modport slave (
    input  In_Chip_Select, In_En_Read, In_Read_Addr,
    output In0_Read_Data, In1_Read_Data,
    input  Out_Chip_Select, Out_En_Write, Out_Write_Addr, Out_Write_Data
  );
endinterface

// File: rtl/dot_product_ctrl_mac.sv
// Combinational lane-wise unsigned multiply and sum of two packed SRAM words.
module dot_lane_mac
  import dot_product_pkg::*;
(
  input  logic [Word_Width-1:0] a,
  input  logic [Word_Width-1:0] b,
  output logic [Acc_Width-1:0]  sum
);

  function automatic logic [Prod_Width-1:0] lane_mul(input logic [Data_Width-1:0] x,
                                                     input logic [Data_Width-1:0] y);
    return Prod_Width'(x) * Prod_Width'(y);
  endfunction

  always_comb begin
    sum = '0;
    for (int i = 0; i < Para_Deg; i++) begin
      sum = sum + Acc_Width'(lane_mul(a[i*Data_Width +: Data_Width],
                                      b[i*Data_Width +: Data_Width]));
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequencer: streams Vec_Len words from two operand SRAMs, accumulates the
// lane-wise dot product and writes the sum to the result SRAM.
module dot_product_ctrl
  import dot_product_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [Addr_Width:0]   Vec_Len,
  input  logic [Addr_Width-1:0] Out_Addr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [Acc_Width-1:0]  Result,
  dot_product_ctrl_if.master    sram
);

  localparam logic [Addr_Width:0] Depth_L = (Addr_Width + 1)'(Ram_Depth);

  state_t                state, state_n;
  logic [Addr_Width:0]   addr_cnt;
  logic [Addr_Width:0]   len_q;
  logic [Addr_Width-1:0] out_addr_q;
  logic                  err_q;
  logic                  vld_p1;
  logic                  len_ok;
  logic [Acc_Width-1:0]  acc;
  logic [Acc_Width-1:0]  lane_sum;

  assign len_ok = (Vec_Len != '0) && (Vec_Len <= Depth_L);

  dot_lane_mac u_mac (
    .a   (sram.In0_Read_Data),
    .b   (sram.In1_Read_Data),
    .sum (lane_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      len_q      <= '0;
      out_addr_q <= '0;
      err_q      <= 1'b0;
      vld_p1     <= 1'b0;
      acc        <= '0;
      Result     <= '0;
    end else begin
      state <= state_n;
      // Stage p1: read data for the address issued last cycle is on the bus.
      vld_p1 <= (state == READ);
      if (vld_p1) begin
        acc <= acc + lane_sum;
      end
      case (state)
        IDLE: begin
          if (Start) begin
            len_q      <= Vec_Len;
            out_addr_q <= Out_Addr;
            addr_cnt   <= '0;
            err_q      <= !len_ok;
            if (len_ok) begin
              acc <= '0;
            end
          end
        end
        READ: addr_cnt <= addr_cnt + 1'b1;
        // Loaded on the way into DONE so Result is already valid while Done is high.
        WRITE: Result <= acc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n              = state;
    Busy                 = (state != IDLE);
    Done                 = 1'b0;
    Err                  = 1'b0;
    sram.In_Chip_Select  = 1'b0;
    sram.In_En_Read      = 1'b0;
    sram.In_Read_Addr    = '0;
    sram.Out_Chip_Select = 1'b0;
    sram.Out_En_Write    = 1'b0;
    sram.Out_Write_Addr  = '0;
    sram.Out_Write_Data  = '0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_n = len_ok ? READ : DONE;
        end
      end
      READ: begin
        sram.In_Chip_Select = 1'b1;
        sram.In_En_Read     = 1'b1;
        sram.In_Read_Addr   = addr_cnt[Addr_Width-1:0];
        if (addr_cnt == len_q - 1'b1) begin
          state_n = DRAIN;
        end
      end
      DRAIN: state_n = WRITE;
      WRITE: begin
        sram.Out_Chip_Select = 1'b1;
        sram.Out_En_Write    = 1'b1;
        sram.Out_Write_Addr  = out_addr_q;
        sram.Out_Write_Data  = acc;
        state_n              = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        Err     = err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Scoreboard bench for dot_product_ctrl with behavioural models of the three SRAMs.
module tb_dot_product_ctrl;
  import dot_product_pkg::*;

  typedef struct {
    logic [Acc_Width-1:0]  res;
    logic                  err;
    logic [Addr_Width-1:0] addr;
    int                    done_cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  Start = 1'b0;
  logic [Addr_Width:0]   Vec_Len = '0;
  logic [Addr_Width-1:0] Out_Addr = '0;
  logic                  Busy, Done, Err;
  logic [Acc_Width-1:0]  Result;

  dot_product_ctrl_if sif ();

  dot_product_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Vec_Len  (Vec_Len),
    .Out_Addr (Out_Addr),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .Result   (Result),
    .sram     (sif)
  );

  logic [Word_Width-1:0] mem0 [Ram_Depth];
  logic [Word_Width-1:0] mem1 [Ram_Depth];
  logic [Word_Width-1:0] mem2 [Ram_Depth];
  logic [Word_Width-1:0] rd0, rd1;
  int                    rd_count [Ram_Depth];
  int                    rd_total = 0;
  int                    wr_cnt = 0;
  int                    done_cnt = 0;
  int                    cyc = 0;
  int                    errors = 0;
  int                    checks = 0;
  logic [Acc_Width-1:0]  last_good = '0;
  exp_t                  q [$];
  exp_t                  e_mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sif.In0_Read_Data = rd0;
  assign sif.In1_Read_Data = rd1;

  always @(posedge clk) begin
    if (sif.In_Chip_Select && sif.In_En_Read) begin
      rd0 <= mem0[sif.In_Read_Addr];
      rd1 <= mem1[sif.In_Read_Addr];
      rd_count[sif.In_Read_Addr]++;
      rd_total++;
    end
    if (sif.Out_Chip_Select && sif.Out_En_Write) begin
      mem2[sif.Out_Write_Addr] <= sif.Out_Write_Data;
      wr_cnt++;
    end
  end

  // Scoreboard: every Done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && Done === 1'b1) begin
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at cycle %0d (no run pending)", cyc);
      end else begin
        e_mon = q.pop_front();
        if (cyc !== e_mon.done_cyc) begin
          errors++;
          $display("FAIL done_latency actual=%0d required=%0d", cyc, e_mon.done_cyc);
        end
        checks++;
        if (Err !== e_mon.err) begin
          errors++;
          $display("FAIL err_flag actual=%0b required=%0b", Err, e_mon.err);
        end
        checks++;
        if (Result !== e_mon.res) begin
          errors++;
          $display("FAIL result actual=%0d required=%0d", Result, e_mon.res);
        end
        if (!e_mon.err) begin
          checks++;
          if (mem2[e_mon.addr] !== e_mon.res) begin
            errors++;
            $display("FAIL sram2_word[%0d] actual=%0d required=%0d",
                     e_mon.addr, mem2[e_mon.addr], e_mon.res);
          end
        end
      end
    end
  end

  function automatic logic [Acc_Width-1:0] model_sum(input int len);
    logic [Acc_Width-1:0]  s;
    logic [Prod_Width-1:0] pa, pb;
    s = '0;
    for (int w = 0; w < len; w++) begin
      for (int i = 0; i < Para_Deg; i++) begin
        pa = Prod_Width'(mem0[w][i*Data_Width +: Data_Width]);
        pb = Prod_Width'(mem1[w][i*Data_Width +: Data_Width]);
        s  = s + Acc_Width'(pa * pb);
      end
    end
    return s;
  endfunction

  task automatic issue_start(input int len, input logic [Addr_Width-1:0] a,
                             input logic [Acc_Width-1:0] res, input logic err);
    exp_t e;
    @(negedge clk);
    Start      = 1'b1;
    Vec_Len    = (Addr_Width + 1)'(len);
    Out_Addr   = a;
    e.res      = res;
    e.err      = err;
    e.addr     = a;
    e.done_cyc = cyc + (err ? 1 : len + 3);
    q.push_back(e);
    if (!err) last_good = res;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({Busy, Done, Err, sif.In_Chip_Select, sif.In_En_Read,
         sif.Out_Chip_Select, sif.Out_En_Write} !== 7'b0) begin
      errors++;
      $display("FAIL %s_ctrl actual=%b required=0000000", name,
               {Busy, Done, Err, sif.In_Chip_Select, sif.In_En_Read,
                sif.Out_Chip_Select, sif.Out_En_Write});
    end
    checks++;
    if ({sif.In_Read_Addr, sif.Out_Write_Addr, sif.Out_Write_Data} !== '0) begin
      errors++;
      $display("FAIL %s_bus actual=%h required=0", name,
               {sif.In_Read_Addr, sif.Out_Write_Addr, sif.Out_Write_Data});
    end
    checks++;
    if (Result !== '0) begin
      errors++;
      $display("FAIL %s_result actual=%0d required=0", name, Result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst       = 1'b0;
    last_good = '0;
  endtask

  task automatic test_one_word();
    int w0;
    mem0[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    mem1[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    mem2[3] = '0;
    w0 = wr_cnt;
    issue_start(1, 4'd3, 32'd70, 1'b0);
    wait_done("one_word");
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL one_word_writes actual=%0d required=1", wr_cnt - w0);
    end
  endtask

  task automatic test_full_depth();
    int rt0, bad;
    for (int i = 0; i < Ram_Depth; i++) begin
      mem0[i]     = '1;
      mem1[i]     = '1;
      rd_count[i] = 0;
    end
    rt0 = rd_total;
    issue_start(16, 4'd0, 32'd4161600, 1'b0);
    wait_done("full_depth");
    checks++;
    if (rd_total - rt0 !== 16) begin
      errors++;
      $display("FAIL full_depth_reads actual=%0d required=16", rd_total - rt0);
    end
    bad = 0;
    for (int i = 0; i < Ram_Depth; i++) if (rd_count[i] !== 1) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_depth_addr_once bad_addrs=%0d required=0", bad);
    end
  endtask

  task automatic test_illegal_len();
    int w0, rt0, d0;
    w0  = wr_cnt;
    rt0 = rd_total;
    d0  = done_cnt;
    issue_start(0, 4'd1, last_good, 1'b1);
    wait_done("len_zero");
    issue_start(17, 4'd2, last_good, 1'b1);
    wait_done("len_17");
    checks++;
    if (wr_cnt !== w0 || rd_total !== rt0) begin
      errors++;
      $display("FAIL illegal_sram_access writes=%0d reads=%0d required=0 0",
               wr_cnt - w0, rd_total - rt0);
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL illegal_done_count actual=%0d required=2", done_cnt - d0);
    end
  endtask

  task automatic test_busy_start();
    int w0, d0;
    for (int i = 0; i < 4; i++) begin
      mem0[i] = $urandom;
      mem1[i] = $urandom;
    end
    w0 = wr_cnt;
    d0 = done_cnt;
    issue_start(4, 4'd7, model_sum(4), 1'b0);
    @(negedge clk);
    Start    = 1'b1;
    Vec_Len  = 5'd2;
    Out_Addr = 4'd9;
    @(negedge clk);
    Start = 1'b0;
    wait_done("busy_start");
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL busy_start_counts writes=%0d dones=%0d required=1 1",
               wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_run();
    int w0, d0;
    for (int i = 0; i < 8; i++) begin
      mem0[i] = $urandom;
      mem1[i] = $urandom;
    end
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    Start    = 1'b1;
    Vec_Len  = 5'd8;
    Out_Addr = 4'd11;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst       = 1'b0;
    last_good = '0;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_cnt !== w0 || done_cnt !== d0) begin
      errors++;
      $display("FAIL mid_reset_dropped writes=%0d dones=%0d required=0 0",
               wr_cnt - w0, done_cnt - d0);
    end
    issue_start(3, 4'd12, model_sum(3), 1'b0);
    wait_done("after_reset");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      mem0[i] = $urandom;
      mem1[i] = $urandom;
    end
    mem2[5] = '0;
    issue_start(3, 4'd2, model_sum(3), 1'b0);
    repeat (5) @(negedge clk);
    // Start raised during the DONE cycle is ignored; held into IDLE it is accepted.
    Start    = 1'b1;
    Vec_Len  = 5'd2;
    Out_Addr = 4'd5;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_busy actual=%b required=0", Busy);
    end
    e.res      = model_sum(2);
    e.err      = 1'b0;
    e.addr     = 4'd5;
    e.done_cyc = cyc + 5;
    q.push_back(e);
    last_good = e.res;
    @(negedge clk);
    Start = 1'b0;
    wait_done("back_to_back");
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_full_depth();
    test_illegal_len();
    test_busy_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
